// File: rtl/ahb_ssram_ctrl_if.sv
// rtl/ahb_ssram_ctrl_if.sv - AHB-Lite bus bundle between the master stage and the SSRAM controller
// Signals:
//   master drives: HSEL, HADDR[AW-1:0], HTRANS[1:0], HSIZE[2:0], HWRITE, HWDATA[31:0], HREADY
//   slave drives : HREADYOUT, HRDATA[31:0], HRESP
interface ahb_ssram_ctrl_if #(parameter int AW = 12);
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_ssram_ctrl.sv
// rtl/ahb_ssram_ctrl.sv - zero-wait AHB-Lite slave for a 32-bit synchronous single-port SRAM
// Ports:
//   HCLK, HRESETn   clock (rising edge) and asynchronous active-low reset
//   bus             ahb_ssram_ctrl_if.slave (HSEL/HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HREADY in,
//                   HREADYOUT=1, HRDATA, HRESP=0 out)
//   SSRAM_CS/WE/ADDR/WDATA  SRAM request (WE bit n enables byte lane n)
//   SSRAM_RDATA     SRAM read data, valid the cycle after a read request
module ahb_ssram_ctrl #(
  parameter int AW = 12
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_ssram_ctrl_if.slave   bus,
  output logic              SSRAM_CS,
  output logic [3:0]        SSRAM_WE,
  output logic [AW-3:0]     SSRAM_ADDR,
  output logic [31:0]       SSRAM_WDATA,
  input  logic [31:0]       SSRAM_RDATA
);
  localparam int WAW = AW - 2;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'b000:  lane_mask = 4'b0001 << a;
      3'b001:  lane_mask = a[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  logic           acc, rd_acc, wr_acc;
  logic [WAW-1:0] req_addr;
  logic [3:0]     req_mask;

  assign acc      = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign rd_acc   = acc & ~bus.HWRITE;
  assign wr_acc   = acc & bus.HWRITE;
  assign req_addr = bus.HADDR[AW-1:2];
  assign req_mask = lane_mask(bus.HSIZE, bus.HADDR[1:0]);

  // Write address phase captured for the following data phase.
  logic           wr_pend;
  logic [WAW-1:0] wr_addr;
  logic [3:0]     wr_mask;

  // One-entry write buffer.
  logic           buf_valid;
  logic [WAW-1:0] buf_addr;
  logic [3:0]     buf_mask;
  logic [31:0]    buf_data;

  // Read data phase state: lanes to override from the write path and their data.
  logic           rd_pend;
  logic [3:0]     rd_mmask;
  logic [31:0]    rd_mdata;
  logic [31:0]    hrdata_q;
  logic [31:0]    rd_merged;

  // A write data phase with an empty buffer and no competing read goes straight
  // to the SRAM. The buffer is therefore only filled when a read claims the
  // data-phase cycle, and the next write address phase (never a read) always
  // drains it before another write data phase can arrive.
  logic wr_through, buf_load;
  assign wr_through = wr_pend & ~buf_valid & ~rd_acc;
  assign buf_load   = wr_pend & ~wr_through;

  // Newest write contents seen by a read address phase; a write in its data
  // phase this cycle is newer than anything already buffered.
  logic           eff_valid;
  logic [WAW-1:0] eff_addr;
  logic [3:0]     eff_mask;
  logic [31:0]    eff_data;
  assign eff_valid = wr_pend | buf_valid;
  assign eff_addr  = wr_pend ? wr_addr    : buf_addr;
  assign eff_mask  = wr_pend ? wr_mask    : buf_mask;
  assign eff_data  = wr_pend ? bus.HWDATA : buf_data;

  always_comb begin
    SSRAM_CS    = 1'b0;
    SSRAM_WE    = 4'b0000;
    SSRAM_ADDR  = '0;
    SSRAM_WDATA = '0;
    if (rd_acc) begin
      SSRAM_CS   = 1'b1;
      SSRAM_ADDR = req_addr;
    end else if (buf_valid) begin
      SSRAM_CS    = 1'b1;
      SSRAM_WE    = buf_mask;
      SSRAM_ADDR  = buf_addr;
      SSRAM_WDATA = buf_data;
    end else if (wr_pend) begin
      SSRAM_CS    = 1'b1;
      SSRAM_WE    = wr_mask;
      SSRAM_ADDR  = wr_addr;
      SSRAM_WDATA = bus.HWDATA;
    end
  end

  always_comb begin
    rd_merged = SSRAM_RDATA;
    for (int i = 0; i < 4; i++) begin
      if (rd_mmask[i]) rd_merged[8*i +: 8] = rd_mdata[8*i +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend   <= 1'b0;
      wr_addr   <= '0;
      wr_mask   <= 4'b0000;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_mask  <= 4'b0000;
      buf_data  <= '0;
      rd_pend   <= 1'b0;
      rd_mmask  <= 4'b0000;
      rd_mdata  <= '0;
      hrdata_q  <= '0;
    end else begin
      wr_pend <= wr_acc;
      if (wr_acc) begin
        wr_addr <= req_addr;
        wr_mask <= req_mask;
      end

      if (buf_load) begin
        buf_valid <= 1'b1;
        buf_addr  <= wr_addr;
        buf_mask  <= wr_mask;
        buf_data  <= bus.HWDATA;
      end else if (buf_valid && !rd_acc) begin
        buf_valid <= 1'b0;
      end

      rd_pend <= rd_acc;
      if (rd_acc) begin
        rd_mmask <= (eff_valid && eff_addr == req_addr) ? eff_mask : 4'b0000;
        rd_mdata <= eff_data;
      end
      if (rd_pend) hrdata_q <= rd_merged;
    end
  end

  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  // Live merged data during a read data phase, otherwise the last value returned.
  assign bus.HRDATA    = rd_pend ? rd_merged : hrdata_q;
endmodule
